saturn_serial_tx: RTL and testbench
===================================

# saturn_serial_tx

Parametrised, buffered UART transmitter that replaces the single-character serial output of the debug path. Characters are pushed through a valid/ready handshake into an internal FIFO and then serialised on `o_serial_tx`. Baud divisor, data width, parity and stop-bit count are set by parameters. A burst of debug characters can be queued without stalling the producer per character.

## Interface
- `CLK_DIV`, 217: clock cycles per bit period; legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: number of entries; a power of two, at least 2.
- `i_clk` input, 1 bit: the single clock.
- `i_reset` input, 1 bit: synchronous, active-high reset.
- `i_char_to_send` input, 8 bits: character to queue. Bits above `DATA_BITS-1` are ignored.
- `i_char_valid` input, 1 bit: the producer offers a character.
- `o_char_ready` output, 1 bit: the FIFO can accept a character. Equals `!full`.
- `o_serial_tx` output, 1 bit: serial line, idle high.
- `o_serial_busy` output, 1 bit: a frame is in progress or the FIFO is not empty.
- `o_fifo_level` output, `$clog2(FIFO_DEPTH)+1` bits: current FIFO occupancy.

## Operation
- **Push.** A character is pushed when `i_char_valid && o_char_ready` on a rising edge. If the FIFO is full, `o_char_ready` is 0 and `i_char_valid` is ignored; no overflow state exists. A producer may hold `i_char_valid` high across cycles, and each accepting edge consumes one character.
- **States.**
  - IDLE: line high. Leaves IDLE only when the FIFO is non-empty.
  - START: line low.
  - DATA: LSB first, `DATA_BITS` bits.
  - PARITY: present only if `PARITY != 0`.
  - STOP: line high, `STOP_BITS` periods.
- **Pop.** In IDLE, or on the last cycle of the final stop period, a non-empty FIFO is popped. The popped character loads the shift register and the FSM enters START. Consecutive frames therefore have no idle gap.
- **Parity.** Computed at load time over the `DATA_BITS` data bits. Odd parity makes the total count of ones in data plus parity odd. Even parity makes it even.
- **Baud counter.** Counts 0..`CLK_DIV-1`. It is cleared on entry to START and advances the FSM on the wrap. Every bit period is exactly `CLK_DIV` cycles.
- **Frame length.** 1 + `DATA_BITS` + (parity ? 1 : 0) + `STOP_BITS` bit periods.
- **Full FIFO.** A push and a pop in the same cycle on a full FIFO: the push is refused, the pop proceeds, and the level drops by 1.
- **Empty FIFO.** A push and a pop-attempt in the same cycle on an empty FIFO: no bypass. The character is popped on a later cycle.
- **Simultaneous push and pop otherwise.** The level is unchanged.
- **Pointers.** Read and write pointers wrap modulo `FIFO_DEPTH`. Full and empty are derived from an extra pointer bit.

## Timing
- **Reset values.** Outputs after reset: `o_serial_tx`=1, `o_serial_busy`=0, `o_char_ready`=1, `o_fifo_level`=0.
- **Reset state.** Reset sets FSM=IDLE, clears the baud counter, and empties the FIFO.
- **Reset mid-frame.** Aborts the frame. The line is high on the cycle after the reset edge, and queued characters are discarded.
- **Reset priority.** Reset overrides any push on the same edge.
- **Output register.** `o_serial_tx` is driven from a register and is glitch-free.
- **Latency, idle transmitter.** A handshake at edge N gives `o_fifo_level`=1 after N and `o_serial_busy`=1 after N. The pop occurs at edge N+1, and `o_serial_tx` falls after edge N+1.
- **Start bit.** Held low for `CLK_DIV` cycles.
- **Busy clear.** `o_serial_busy` clears on the cycle after the final stop period ends, and only if the FIFO is empty.
- **`o_char_ready` update.** Updates on the edge after a push or pop changes full status; it is registered, not combinational from `i_char_valid`.

## Structure
- **Shared package `saturn_serial_pkg`.** Holds the parity-mode constants (`PARITY_NONE`/`ODD`/`EVEN`) and the FSM state encodings (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`). Another UART block later consumes these.
- **Sub-module `saturn_serial_fifo`.** Synchronous FIFO, parametrised by width and depth, with push/pop/full/empty/level ports. It is reusable by the future receive side.
- **Top-level contents.** The FSM, baud counter, bit counter and shift register.
- **Parameter checks.** Illegal parameters trigger an elaboration-time `$error` under `SIM`.

## Test plan
- **Single character.** `CLK_DIV`=4, 8N1, push 0x41 from idle → `o_serial_tx` reads 0,1,0,0,0,0,0,1,0,1, each bit for 4 cycles. The start bit falls 2 edges after the handshake, and `o_serial_busy` drops after 40 cycles of frame.
- **Parity and stop bits.** `PARITY`=2, `STOP_BITS`=2, `DATA_BITS`=7, push 0x03 → 7 data bits 1100000, parity bit 0, then two high stop periods. With `PARITY`=1 the parity bit is 1.
- **Full FIFO.** `FIFO_DEPTH`=4, `i_char_valid` held high with 6 distinct characters → 4 or 5 are accepted (one pop frees a slot). `o_char_ready`=0 while the level is 4. All accepted characters appear in order with no inter-frame gap.
- **Full with push and pop.** Full FIFO, push attempted on the pop edge → push refused and level goes 4→3. The producer's next attempt succeeds.
- **Reset mid-frame.** Assert `i_reset` at data bit 3 with 2 characters queued → line high next cycle, level 0, busy 0, ready 1. No further frame starts.
- **Busy across frames.** Two characters back to back → `o_serial_busy` stays high continuously across both frames.

Source files
------------

// File: rtl/saturn_serial_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encodings and a parity helper.
// Also consumed by the receive side, so keep encodings stable.
package saturn_serial_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity bit over the low data_bits of dat; odd mode inverts the XOR reduction.
  function automatic logic frame_parity(input logic [7:0] dat, input int data_bits, input int mode);
    logic [7:0] mask;
    mask = 8'hFF >> (8 - data_bits);
    return (mode == PARITY_ODD) ? ~(^(dat & mask)) : ^(dat & mask);
  endfunction

endpackage

// File: rtl/saturn_serial_fifo.sv
// Synchronous show-ahead FIFO; push ignored when full, pop ignored when empty.
// Read data is the head entry combinationally; no push-to-pop bypass.
module saturn_serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/saturn_serial_tx.sv
// Buffered UART transmitter: valid/ready push into a FIFO, frames serialised back to back.
// Idle handshake at edge N pops at N+1 and drops the line after N+1; producer stalls only on a full FIFO.
module saturn_serial_tx
  import saturn_serial_pkg::*;
#(
  parameter int CLK_DIV    = 217,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [7:0]                    i_char_to_send,
  input  logic                          i_char_valid,
  output logic                          o_char_ready,
  output logic                          o_serial_tx,
  output logic                          o_serial_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
  localparam int              CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]      DATA_MASK = 8'hFF >> (8 - DATA_BITS);

`ifdef SIM
  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_chk_div
    $error("saturn_serial_tx: CLK_DIV must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data
    $error("saturn_serial_tx: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("saturn_serial_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("saturn_serial_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("saturn_serial_tx: FIFO_DEPTH must be a power of two >= 2");
  end
`endif

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dat;
  logic          fifo_push;
  logic          fifo_pop;
  logic          baud_wrap;

  assign baud_wrap     = (baud_cnt == BAUD_LAST);
  assign fifo_push     = i_char_valid && !fifo_full;
  // Popping on the final stop cycle chains frames with no idle gap.
  assign fifo_pop      = !fifo_empty &&
                         ((state == ST_IDLE) ||
                          (state == ST_STOP && baud_wrap && bit_cnt == STOP_LAST));
  assign o_char_ready  = !fifo_full;
  assign o_serial_busy = (state != ST_IDLE) || !fifo_empty;

  saturn_serial_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .push     (fifo_push),
    .push_dat (i_char_to_send),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (o_fifo_level)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      o_serial_tx <= 1'b1;
    end else begin
      baud_cnt <= baud_wrap ? '0 : baud_cnt + CW'(1);
      case (state)
        ST_IDLE: begin
          baud_cnt    <= '0;
          o_serial_tx <= 1'b1;
        end
        ST_START: begin
          if (baud_wrap) begin
            state       <= ST_DATA;
            bit_cnt     <= '0;
            o_serial_tx <= shreg[0];
            shreg       <= shreg >> 1;
          end
        end
        ST_DATA: begin
          if (baud_wrap) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state       <= ST_PARITY;
                o_serial_tx <= par_bit;
              end else begin
                state       <= ST_STOP;
                o_serial_tx <= 1'b1;
              end
            end else begin
              bit_cnt     <= bit_cnt + 3'd1;
              o_serial_tx <= shreg[0];
              shreg       <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_wrap) begin
            state       <= ST_STOP;
            o_serial_tx <= 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_wrap) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= ST_IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          o_serial_tx <= 1'b1;
        end
      endcase

      // Frame load overrides whatever the case decided for this edge.
      if (fifo_pop) begin
        state       <= ST_START;
        baud_cnt    <= '0;
        bit_cnt     <= '0;
        shreg       <= fifo_dat & DATA_MASK;
        par_bit     <= frame_parity(fifo_dat, DATA_BITS, PARITY);
        o_serial_tx <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_saturn_serial_tx.sv
// Scoreboard bench: stimulus queues expected frames, line monitors decode and compare them.
module tb_saturn_serial_tx;
  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic       a_reset = 1'b1, a_valid = 1'b0;
  logic [7:0] a_data  = 8'h00;
  logic       a_ready, a_tx, a_busy;
  logic [2:0] a_level;

  logic       bc_reset = 1'b1, b_valid = 1'b0, c_valid = 1'b0;
  logic [7:0] bc_data  = 8'h00;
  logic       b_ready, b_tx, b_busy, c_ready, c_tx, c_busy;
  logic [2:0] b_level, c_level;

  saturn_serial_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_char_to_send(a_data), .i_char_valid(a_valid),
    .o_char_ready(a_ready), .o_serial_tx(a_tx), .o_serial_busy(a_busy), .o_fifo_level(a_level));

  saturn_serial_tx #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_reset(bc_reset), .i_char_to_send(bc_data), .i_char_valid(b_valid),
    .o_char_ready(b_ready), .o_serial_tx(b_tx), .o_serial_busy(b_busy), .o_fifo_level(b_level));

  saturn_serial_tx #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .i_clk(clk), .i_reset(bc_reset), .i_char_to_send(bc_data), .i_char_valid(c_valid),
    .o_char_ready(c_ready), .o_serial_tx(c_tx), .o_serial_busy(c_busy), .o_fifo_level(c_level));

  logic [2:0] txs, rsts;
  assign txs  = {c_tx, b_tx, a_tx};
  assign rsts = {bc_reset, bc_reset, a_reset};

  // Frames stored with bit 0 = start bit, in line order.
  logic [15:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int          starts_a[$];

  logic [7:0] full_chars [6] = '{8'h10, 8'h2F, 8'hC4, 8'h5A, 8'hE7, 8'h99};

  function automatic logic [15:0] f8n1(input logic [7:0] c);
    return {6'b0, 1'b1, c, 1'b0};
  endfunction

  function automatic int exp_size(input int idx);
    case (idx)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic exp_pop(input int idx, output logic [15:0] v);
    case (idx)
      0:       v = exp_q0.pop_front();
      1:       v = exp_q1.pop_front();
      default: v = exp_q2.pop_front();
    endcase
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic monitor(input int idx, input int nbits);
    logic [15:0] got, want;
    bit          stable, aborted;
    int          first;
    forever begin
      @(negedge clk);
      if (txs[idx] == 1'b0 && rsts[idx] == 1'b0) begin
        got = '0; stable = 1'b1; aborted = 1'b0; first = cyc;
        for (int k = 0; k < nbits * DIV; k++) begin
          if (k > 0) @(negedge clk);
          if (rsts[idx]) begin aborted = 1'b1; break; end
          if (k % DIV == 0) got[k / DIV] = txs[idx];
          else if (txs[idx] != got[k / DIV]) stable = 1'b0;
        end
        if (!aborted) begin
          n_checks++;
          if (exp_size(idx) == 0) begin
            n_fail++;
            $display("FAIL frame_unexpected dut%0d: got frame %h, required none", idx, got);
          end else begin
            exp_pop(idx, want);
            if (got !== want || !stable) begin
              n_fail++;
              $display("FAIL frame dut%0d: got %h (stable=%0d), required %h", idx, got, stable, want);
            end
          end
          if (idx == 0) starts_a.push_back(first);
        end
      end
    end
  endtask

  initial monitor(0, 10);
  initial monitor(1, 11);
  initial monitor(2, 11);

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size() != 0 || a_busy || b_busy || c_busy)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(n >= 2000), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok, acc, gap_ok;
    int n_acc;

    repeat (3) @(negedge clk);
    check("rst_tx", int'(a_tx), 1);
    check("rst_busy", int'(a_busy), 0);
    check("rst_ready", int'(a_ready), 1);
    check("rst_level", int'(a_level), 0);
    check("rst_b_tx", int'(b_tx), 1);
    check("rst_c_ready", int'(c_ready), 1);
    a_reset = 1'b0; bc_reset = 1'b0;
    @(negedge clk);

    // Single 8N1 character 0x41: line 0,1,0,0,0,0,0,1,0,1.
    starts_a.delete();
    a_valid = 1'b1; a_data = 8'h41; exp_q0.push_back(16'h0282);
    @(negedge clk);
    a_valid = 1'b0;
    check("hs_level", int'(a_level), 1);
    check("hs_busy", int'(a_busy), 1);
    check("hs_tx_still_high", int'(a_tx), 1);
    @(negedge clk);
    check("start_fall", int'(a_tx), 0);
    repeat (39) @(negedge clk);
    check("busy_last_stop", int'(a_busy), 1);
    @(negedge clk);
    check("busy_clear", int'(a_busy), 0);
    check("idle_tx", int'(a_tx), 1);
    drain("drain_single");

    // Two characters back to back: busy never drops between frames.
    starts_a.delete();
    a_valid = 1'b1; a_data = 8'h55; exp_q0.push_back(f8n1(8'h55));
    @(negedge clk);
    a_data = 8'hA3; exp_q0.push_back(f8n1(8'hA3));
    @(negedge clk);
    a_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (!a_busy) ok = 1'b0;
      @(negedge clk);
    end
    check("busy_continuous", int'(ok), 1);
    check("busy_clear_two", int'(a_busy), 0);
    drain("drain_two");
    check("two_frame_gap", (starts_a.size() == 2) ? starts_a[1] - starts_a[0] : -1, 10 * DIV);

    // Full FIFO with valid held high; refused push on the pop edge, accepted next.
    starts_a.delete();
    n_acc = 0; a_data = full_chars[0]; a_valid = 1'b1;
    for (int t = 0; t <= 42; t++) begin
      acc = a_valid && a_ready;
      @(negedge clk);
      if (acc) begin
        exp_q0.push_back(f8n1(full_chars[n_acc]));
        n_acc++;
        if (n_acc < 6) a_data = full_chars[n_acc];
        else a_valid = 1'b0;
      end
      if (t == 4) begin
        check("full_level", int'(a_level), 4);
        check("full_ready", int'(a_ready), 0);
        check("full_accepted", n_acc, 5);
      end
      if (t == 40) begin
        check("full_hold_level", int'(a_level), 4);
        check("full_hold_ready", int'(a_ready), 0);
      end
      if (t == 41) begin
        check("pop_on_full_level", int'(a_level), 3);
        check("pop_on_full_ready", int'(a_ready), 1);
      end
      if (t == 42) begin
        check("refill_level", int'(a_level), 4);
        check("refill_accepted", n_acc, 6);
      end
    end
    a_valid = 1'b0;
    drain("drain_full");
    gap_ok = (starts_a.size() == 6);
    for (int i = 1; i < starts_a.size(); i++)
      if (starts_a[i] - starts_a[i-1] != 10 * DIV) gap_ok = 1'b0;
    check("full_no_gap", int'(gap_ok), 1);

    // Reset during data bit 3 with two characters still queued.
    a_valid = 1'b1; a_data = 8'h21;
    @(negedge clk); a_data = 8'h22;
    @(negedge clk); a_data = 8'h23;
    @(negedge clk); a_valid = 1'b0;
    check("rst_mid_queued", int'(a_level), 2);
    repeat (16) @(negedge clk);
    check("rst_mid_bit3_low", int'(a_tx), 0);
    a_reset = 1'b1; a_valid = 1'b1; a_data = 8'h7E;
    @(negedge clk);
    check("rst_mid_tx", int'(a_tx), 1);
    check("rst_mid_level", int'(a_level), 0);
    check("rst_mid_busy", int'(a_busy), 0);
    check("rst_mid_ready", int'(a_ready), 1);
    @(negedge clk);
    a_reset = 1'b0; a_valid = 1'b0;
    check("rst_priority_level", int'(a_level), 0);
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!a_tx || a_busy) ok = 1'b0;
    end
    check("rst_no_restart", int'(ok), 1);

    // 7E2 and 7O2 with bit 7 set: it is ignored for data and parity.
    b_valid = 1'b1; c_valid = 1'b1; bc_data = 8'h83;
    exp_q1.push_back(16'h0606);
    exp_q2.push_back(16'h0706);
    @(negedge clk);
    b_valid = 1'b0; c_valid = 1'b0;
    check("b_level", int'(b_level), 1);
    drain("drain_parity");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
